// File: rtl/mem_stage.sv
// Memory stage: M pipeline register plus word-addressed data memory with
// asynchronous read and a single write port that commits as the store leaves M.
module mem_stage #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic [31:0] e_valE,
    input  logic [31:0] E_valA,
    input  logic [4:0]  e_dstE,
    input  logic [4:0]  E_dstM,
    input  logic        E_mem_read,
    input  logic        E_mem_write,
    output logic [31:0] M_valE,
    output logic [31:0] M_valA,
    output logic [4:0]  M_dstE,
    output logic [4:0]  M_dstM,
    output logic        M_mem_read,
    output logic        M_mem_write,
    output logic [31:0] m_valM,
    output logic        m_err
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic          misaligned;
    logic          out_of_range;
    logic          mem_write_en;

    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            M_valE      <= '0;
            M_valA      <= '0;
            M_dstE      <= '0;
            M_dstM      <= '0;
            M_mem_read  <= 1'b0;
            M_mem_write <= 1'b0;
        end else if (!M_stall) begin
            M_valE      <= e_valE;
            M_valA      <= E_valA;
            M_dstE      <= e_dstE;
            M_dstM      <= E_dstM;
            M_mem_read  <= E_mem_read;
            M_mem_write <= E_mem_write;
        end
    end

    assign word_idx     = M_valE[AW+1:2];
    assign misaligned   = (M_valE[1:0] != 2'b00);
    assign out_of_range = (M_valE[31:AW+2] != '0);
    assign m_err        = (M_mem_read | M_mem_write) & (misaligned | out_of_range);

    // A stalled store waits; it commits on the first unstalled edge only.
    assign mem_write_en = M_mem_write & ~m_err & ~M_stall & ~rst;

    always_ff @(posedge clk) begin
        if (mem_write_en) begin
            mem[word_idx] <= M_valA;
        end
    end

    // Read is asynchronous, so a combined read/write sees the pre-write word.
    always_comb begin
        m_valM = '0;
        if (M_mem_read && !m_err) begin
            m_valM = mem[word_idx];
        end
    end
endmodule
